pit_irq_ctrl: RTL

Interrupt-capture stage directly downstream of the mini PIT. It consumes the timer's single-cycle expiry pulse and latches it as a pending interrupt until software or the host acknowledges it. It drives the external interrupt pin in either level mode or stretched-pulse mode. It also keeps an accepted-tick count and a saturating overrun count for ticks that arrive while an interrupt is still pending.

---
 rtl/pit_pkg.sv | 13 +
 rtl/pit_sat_counter.sv | 24 ++
 rtl/pit_irq_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/pit_pkg.sv
// Shared PIT types and default widths; no logic, no latency, no flow control.
package pit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pit_irq_state_t;

  localparam int PIT_CNT_W   = 8;
  localparam int PIT_TOT_W   = 16;
  localparam int PIT_STRETCH = 4;

endpackage

// File: rtl/pit_sat_counter.sv
// Up-counter with clear-over-increment priority and a saturate/wrap select.
// Updates on the edge after inc/clr; always accepts, no backpressure.
module pit_sat_counter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (!(SAT && (cnt == {W{1'b1}}))) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/pit_irq_ctrl.sv
// Latches PIT expiry ticks as a pending irq, drives level or stretched-pulse irq_out.
// One-cycle latency tick/ack to outputs; all outputs registered; no backpressure.
module pit_irq_ctrl
  import pit_pkg::*;
#(
  parameter int CNT_W   = PIT_CNT_W,
  parameter int TOT_W   = PIT_TOT_W,
  parameter int STRETCH = PIT_STRETCH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             mask,
  input  logic             level_mode,
  input  logic             ack,
  input  logic             clr_stats,
  output logic             irq_out,
  output logic             pending,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic [TOT_W-1:0] tick_total
);

  localparam int SW = $clog2(STRETCH + 1);

  if (STRETCH < 1) begin : g_bad_stretch
    $error("pit_irq_ctrl: STRETCH must be >= 1");
  end

  pit_irq_state_t state, state_nxt;
  logic [SW-1:0]  stretch, stretch_nxt;
  logic           accepted;
  logic           load;
  logic           overrun;
  logic           irq_nxt;

  assign accepted = tick_in & ~mask;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    overrun   = 1'b0;
    case (state)
      IDLE: begin
        if (accepted) begin
          state_nxt = PEND;
          load      = 1'b1;
        end
      end
      PEND: begin
        if (accepted && ack) begin
          load = 1'b1;
        end else if (accepted) begin
          overrun = 1'b1;
        end else if (ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      stretch_nxt = SW'(STRETCH);
    end else if (stretch != '0) begin
      stretch_nxt = stretch - SW'(1);
    end else begin
      stretch_nxt = '0;
    end

    irq_nxt = level_mode ? (state_nxt == PEND) : (stretch_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      stretch <= '0;
      irq_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      stretch <= stretch_nxt;
      irq_out <= irq_nxt;
    end
  end

  assign pending = (state == PEND);

  pit_sat_counter #(.W(CNT_W), .SAT(1'b1)) u_overrun (
    .clk   (clk),
    .reset (reset),
    .inc   (overrun),
    .clr   (clr_stats),
    .cnt   (overrun_cnt)
  );

  pit_sat_counter #(.W(TOT_W), .SAT(1'b0)) u_total (
    .clk   (clk),
    .reset (reset),
    .inc   (accepted),
    .clr   (clr_stats),
    .cnt   (tick_total)
  );

endmodule
